// File: rtl/fir_decim_mc.sv
// fir_decim_mc: multi-channel decimating FIR for the FM radio datapath.
// Reads channel-interleaved samples from an upstream FWFT FIFO. Each channel
// has its own TAPS-deep delay line. Every DECIM input frames, the block
// computes one output per channel with a sequential MAC (one tap per cycle).
// It then pushes the dequantised results, channel-interleaved, to a
// downstream FIFO. Coefficients can be written while the block is idle.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-low
//   in_empty    upstream FIFO empty
//   in_rd_en    pop upstream; in_dout is valid in the same cycle (FWFT)
//   in_dout     upstream sample (signed)
//   out_full    downstream FIFO full
//   out_wr_en   push out_din downstream
//   out_din     filtered sample (signed)
//   coef_wr_en  coefficient write strobe (ignored while busy)
//   coef_addr   tap index; tap 0 multiplies the newest sample
//   coef_din    coefficient value (signed, QUANT_BITS fraction bits)
//   busy        high while computing or writing results
module fir_decim_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int CHANNELS   = 2,
    parameter int DECIM      = 1,
    parameter int QUANT_BITS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_empty,
    output logic                    in_rd_en,
    input  logic [DATA_WIDTH-1:0]   in_dout,
    input  logic                    out_full,
    output logic                    out_wr_en,
    output logic [DATA_WIDTH-1:0]   out_din,
    input  logic                    coef_wr_en,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]   coef_din,
    output logic                    busy
);

    localparam int TAP_W = $clog2(TAPS);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FR_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + TAP_W;

    typedef enum logic [1:0] {
        S_READ,
        S_MAC,
        S_WRITE
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0]   line [CHANNELS][TAPS];
    logic [COEF_WIDTH-1:0]   coef [TAPS];
    logic [CH_W-1:0]         ch;
    logic [CH_W-1:0]         mac_ch;
    logic [FR_W-1:0]         frame;
    logic [TAP_W-1:0]        tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] mac_prod;

    logic last_ch, last_frame, last_tap, last_mac_ch;

    assign last_ch     = (ch == CH_W'(CHANNELS - 1));
    assign last_frame  = (frame == FR_W'(DECIM - 1));
    assign last_tap    = (tap == TAP_W'(TAPS - 1));
    assign last_mac_ch = (mac_ch == CH_W'(CHANNELS - 1));

    // Both operands are sign-extended to the accumulator width, so the
    // product is exact and can be added without further extension.
    always_comb begin
        mac_prod = ACC_W'($signed(coef[tap])) * ACC_W'($signed(line[mac_ch][tap]));
    end

    // Arithmetic shift floors toward -inf; the cast keeps only the low bits.
    always_comb begin
        out_din = DATA_WIDTH'(acc >>> QUANT_BITS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_READ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            S_READ: begin
                // Gated by reset so that no pop is requested while reset is held.
                in_rd_en = reset && !in_empty;
                if (!in_empty && last_ch && last_frame) begin
                    next_state = S_MAC;
                end
            end
            S_MAC: begin
                busy = 1'b1;
                if (last_tap) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                out_wr_en = !out_full;
                if (!out_full) begin
                    next_state = last_mac_ch ? S_READ : S_MAC;
                end
            end
            default: next_state = S_READ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned i = 0; i < TAPS; i++) begin
                    line[c][i] <= '0;
                end
            end
            ch     <= '0;
            frame  <= '0;
            mac_ch <= '0;
            tap    <= '0;
            acc    <= '0;
        end else begin
            if (in_rd_en) begin
                for (int unsigned i = TAPS - 1; i > 0; i--) begin
                    line[ch][i] <= line[ch][i-1];
                end
                line[ch][0] <= in_dout;
                if (last_ch) begin
                    ch <= '0;
                    if (last_frame) begin
                        frame  <= '0;
                        mac_ch <= '0;
                    end else begin
                        frame <= frame + 1'b1;
                    end
                end else begin
                    ch <= ch + 1'b1;
                end
            end

            if (state == S_MAC) begin
                acc <= acc + mac_prod;
                tap <= last_tap ? '0 : tap + 1'b1;
            end

            if (out_wr_en) begin
                acc    <= '0;
                mac_ch <= last_mac_ch ? '0 : mac_ch + 1'b1;
            end
        end
    end

    // A write is accepted in the same cycle as the pop that starts a MAC.
    // busy is still low in that cycle, and the new value is registered before
    // the first MAC cycle reads it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr_en && !busy) begin
            coef[coef_addr] <= coef_din;
        end
    end

endmodule

// File: tb/tb_fir_decim_mc.sv
module tb_fir_decim_mc;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int TP = 4;
    localparam int CH = 2;
    localparam int DC = 2;
    localparam int QB = 10;
    localparam int AW = $clog2(TP);
    localparam int FRAME_WORDS = CH * DC;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_empty = 1'b1;
    logic          in_rd_en;
    logic [DW-1:0] in_dout = '0;
    logic          out_full = 1'b0;
    logic          out_wr_en;
    logic [DW-1:0] out_din;
    logic          coef_wr_en = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_din = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] exp_q[$];
    longint        coef_m[TP];
    longint        hist[CH][TP];
    int            wcnt = 0;
    int            stall_pct = 0;
    int            full_pct = 0;
    bit            force_full = 1'b0;

    always #5 clock = ~clock;

    fir_decim_mc #(
        .DATA_WIDTH(DW),
        .COEF_WIDTH(CW),
        .TAPS(TP),
        .CHANNELS(CH),
        .DECIM(DC),
        .QUANT_BITS(QB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .in_dout(in_dout),
        .out_full(out_full),
        .out_wr_en(out_wr_en),
        .out_din(out_din),
        .coef_wr_en(coef_wr_en),
        .coef_addr(coef_addr),
        .coef_din(coef_din),
        .busy(busy)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model. Word k belongs to channel k mod CH. After every
    // CH*DECIM words, each channel yields the dot product of its coefficients
    // with its newest TP samples. The result is floored by 2^QB and wrapped to DW bits.
    function automatic void model_push(input logic [DW-1:0] x);
        int c;
        longint acc;
        c = wcnt % CH;
        for (int t = TP - 1; t > 0; t--) hist[c][t] = hist[c][t-1];
        hist[c][0] = longint'($signed(x));
        wcnt++;
        if (wcnt == FRAME_WORDS) begin
            wcnt = 0;
            for (int k = 0; k < CH; k++) begin
                acc = 0;
                for (int t = 0; t < TP; t++) acc += coef_m[t] * hist[k][t];
                acc = acc >>> QB;
                exp_q.push_back(acc[DW-1:0]);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < CH; k++)
            for (int t = 0; t < TP; t++) hist[k][t] = 0;
        for (int t = 0; t < TP; t++) coef_m[t] = 0;
        wcnt = 0;
        exp_q.delete();
        in_q.delete();
    endfunction

    // Upstream FWFT FIFO and downstream full flag. Pops are observed just
    // before the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (in_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
                in_empty = 1'b0;
                in_dout  = in_q[0];
            end else begin
                in_empty = 1'b1;
                in_dout  = DW'($urandom);
            end
            out_full = force_full || ($urandom_range(99) < full_pct);
            #4;
            if (in_rd_en) begin
                check("rd_while_empty", in_empty, 0);
                if (!in_empty) model_push(in_q.pop_front());
            end
        end
    end

    // Monitor: compares each pushed output with the scoreboard head.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clock);
            #4;
            if (reset && out_wr_en) begin
                check("wr_while_full", out_full, 0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual=%0d required=none", $signed(out_din));
                end else begin
                    e = exp_q.pop_front();
                    if (out_din !== e) begin
                        errors++;
                        $display("FAIL out_din actual=%0d required=%0d", $signed(out_din), $signed(e));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic load_coef(input int t, input longint v);
        @(negedge clock);
        coef_wr_en = 1'b1;
        coef_addr  = AW'(t);
        coef_din   = CW'(v);
        coef_m[t]  = v;
        @(negedge clock);
        coef_wr_en = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] x);
        in_q.push_back(x);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s actual=timeout in_q=%0d exp_q=%0d required=drained",
                     name, in_q.size(), exp_q.size());
        end
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        @(negedge clock);
        while (!busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, busy, 1);
    endtask

    task automatic send_ramp();
        logic [DW-1:0] v;
        for (int i = 1; i <= 4; i++) begin
            v = DW'(i);
            send(v);
            v = DW'(i * 100);
            send(v);
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        bit bad;

        // Reset state, with data offered upstream.
        in_q.push_back(DW'(7));
        @(negedge clock);
        #2;
        check("rst_in_rd_en", in_rd_en, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_out_din", out_din, 0);
        check("rst_busy", busy, 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // All-unity coefficients with two channels: running sums, decimated.
        for (int t = 0; t < TP; t++) load_coef(t, 1024);
        send_ramp();
        wait_drain("drain_unity");

        // Floor behaviour of the dequantiser.
        load_coef(0, 1);
        for (int t = 1; t < TP; t++) load_coef(t, 0);
        send(DW'(1023)); send(DW'(-1)); send(DW'(-1)); send(DW'(1023));
        wait_drain("drain_floor");
        load_coef(0, -1024);
        send(DW'(5)); send(DW'(6)); send(DW'(7)); send(DW'(-8));
        wait_drain("drain_neg");

        // Random coefficients and data with upstream stalls and downstream backpressure.
        for (int t = 0; t < TP; t++) load_coef(t, longint'($signed(CW'($urandom))));
        stall_pct = 30;
        full_pct  = 30;
        for (int i = 0; i < 40 * FRAME_WORDS; i++) begin
            v = DW'($urandom);
            send(v);
        end
        wait_drain("drain_random");
        stall_pct = 0;
        full_pct  = 0;

        // A coefficient write while busy must be ignored.
        for (int i = 0; i < FRAME_WORDS; i++) begin
            v = DW'($urandom_range(1, 30000));
            send(v);
        end
        wait_busy("busy_for_coef");
        coef_wr_en = 1'b1;
        coef_addr  = '0;
        coef_din   = CW'(16'h7abc);
        @(negedge clock);
        coef_wr_en = 1'b0;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            v = DW'($urandom_range(1, 30000));
            send(v);
        end
        wait_drain("drain_busy_coef");

        // Held backpressure: no pushes and no pops until released.
        force_full = 1'b1;
        for (int i = 0; i < 2 * FRAME_WORDS; i++) begin
            v = DW'($urandom);
            send(v);
        end
        wait_busy("busy_for_full");
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #4;
            if (out_wr_en || in_rd_en) bad = 1'b1;
        end
        check("hold_while_full", bad, 0);
        check("no_pop_while_full", in_q.size(), FRAME_WORDS);
        force_full = 1'b0;
        wait_drain("drain_full");

        // Reset in the middle of a MAC drops the pending results.
        send_ramp();
        wait_busy("busy_for_reset");
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_in_rd_en", in_rd_en, 0);
        check("mid_rst_out_wr_en", out_wr_en, 0);
        check("mid_rst_out_din", out_din, 0);
        check("mid_rst_busy", busy, 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int t = 0; t < TP; t++) load_coef(t, 1024);
        send_ramp();
        wait_drain("drain_after_reset");
        repeat (10) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
